// File: rtl/reg_file_pkg.sv
// ----------------------------------------------------------------------------
// reg_file_pkg
// Shared constants and types for the 16-bit RISC register file.
//   DATA_W   : register / data-port width
//   ADDR_W   : register-address width
//   NUM_REGS : register count, always 2**ADDR_W
// Optional feature macro used by the files importing this package:
//   REGFILE_BYPASS_EN : compile in write-to-read forwarding
// ----------------------------------------------------------------------------
package reg_file_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // True when a read address targets the register being written this cycle.
  function automatic logic addr_match(input addr_t raddr, input addr_t waddr);
    return (raddr == waddr);
  endfunction

endpackage : reg_file_pkg

// File: rtl/reg_file_rd_port.sv
// ----------------------------------------------------------------------------
// reg_file_rd_port
// One asynchronous read port: a NUM_REGS:1 mux over the stored registers,
// plus (REGFILE_BYPASS_EN only) a forwarding compare against the write port.
// Ports:
//   regs_i : stored register contents
//   raddr  : read address
//   rst    : reset (bypass build only; forwarding is suppressed in reset)
//   waddr  : write address (bypass build only)
//   wdata  : write data    (bypass build only)
//   rdata  : read data, purely combinational
// Macro: REGFILE_BYPASS_EN adds the forwarding path and its ports. Without it
// there is no path from the write data to rdata.
// ----------------------------------------------------------------------------
module reg_file_rd_port
  import reg_file_pkg::*;
(
  input  data_t regs_i [NUM_REGS],
  input  addr_t raddr,
`ifdef REGFILE_BYPASS_EN
  input  logic  rst,
  input  addr_t waddr,
  input  data_t wdata,
`endif
  output data_t rdata
);

  always_comb begin
    rdata = regs_i[raddr];
`ifdef REGFILE_BYPASS_EN
    // The write port has no enable, so any non-reset cycle is a write; a
    // reader of the same register sees the value that will land at the edge.
    if (!rst && addr_match(raddr, waddr)) begin
      rdata = wdata;
    end
`endif
  end

endmodule : reg_file_rd_port

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
// 16 x 16-bit general-purpose register file: two asynchronous read ports
// (A, B) and one synchronous write port with no enable.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset, clears every register
//   rs, rt  : read addresses for ports A and B
//   rd      : write address, written on every non-reset edge
//   data_in : write data
//   A, B    : contents of registers rs and rt
// Macro: REGFILE_BYPASS_EN compiles in write-to-read forwarding on A and B.
// Handshake note: there is no valid/ready pairing here; every cycle with
// rst=0 is an accepted write, so upstream must park rd/data_in on a harmless
// target when it has nothing to write.
// ----------------------------------------------------------------------------
module reg_file
  import reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  data_t regs_q [NUM_REGS];
  data_t regs_d [NUM_REGS];

  // Next state: hold everything, overwrite the addressed register.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    regs_d[rd] = data_in;
  end

  // Reset wins over the write on the same edge. r0 is an ordinary register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  reg_file_rd_port u_port_a (
    .regs_i (regs_q),
    .raddr  (rs),
`ifdef REGFILE_BYPASS_EN
    .rst    (rst),
    .waddr  (rd),
    .wdata  (data_in),
`endif
    .rdata  (A)
  );

  reg_file_rd_port u_port_b (
    .regs_i (regs_q),
    .raddr  (rt),
`ifdef REGFILE_BYPASS_EN
    .rst    (rst),
    .waddr  (rd),
    .wdata  (data_in),
`endif
    .rdata  (B)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// ----------------------------------------------------------------------------
// tb_reg_file
// Self-checking bench for reg_file. A behavioural memory array models the
// register file; expected read values are derived from it (with forwarding
// applied when REGFILE_BYPASS_EN is defined) and from directed constants.
// ----------------------------------------------------------------------------
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic [3:0]  rd;
  logic [15:0] data_in;
  logic [15:0] A;
  logic [15:0] B;

  int n_cmp;
  int n_err;

  logic [15:0] mem [16];
  logic [15:0] exp_q [$];

  reg_file dut (
    .clk     (clk),
    .rst     (rst),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .data_in (data_in),
    .A       (A),
    .B       (B)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference read: stored value, or the pending write data when forwarding.
  function automatic logic [15:0] ref_read(input logic [3:0] addr);
    logic [15:0] v;
    v = mem[addr];
`ifdef REGFILE_BYPASS_EN
    if (!rst && addr == rd) v = data_in;
`endif
    return v;
  endfunction

  // One clock edge: update the model from the inputs held across the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    end else begin
      mem[rd] = data_in;
    end
    #1;
  endtask

  // Scoreboard comparison through the expected queue.
  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] expv);
    logic [15:0] e;
    exp_q.push_back(expv);
    e = exp_q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic check_ports(input string tag);
    #1;
    check({tag, ".A"}, A, ref_read(rs));
    check({tag, ".B"}, B, ref_read(rt));
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    rs      = 4'd0;
    rt      = 4'd0;
    rd      = 4'd15;
    data_in = 16'h0000;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;

    // Reset: one edge with rst=1, then sweep all addresses.
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rs = 4'(i);
      rt = 4'(15 - i);
      #1;
      check("reset_sweep.A", A, 16'h0000);
      check("reset_sweep.B", B, 16'h0000);
    end

    // Basic write/read.
    rd = 4'd2; data_in = 16'hAAAA;
    tick();
    rs = 4'd2; rt = 4'd1;
    #1;
    check("basic.A", A, 16'hAAAA);
    check("basic.B", B, 16'h0000);

    // Dual read, then rs == rt.
    rd = 4'd3; data_in = 16'h1234; tick();
    rd = 4'd7; data_in = 16'hBEEF; tick();
    rs = 4'd3; rt = 4'd7;
    #1;
    check("dual.A", A, 16'h1234);
    check("dual.B", B, 16'hBEEF);
    rs = 4'd7;
    #1;
    check("same_addr.A", A, 16'hBEEF);
    check("same_addr.B", B, 16'hBEEF);

    // Same-cycle read of the write target.
    rd = 4'd5; data_in = 16'h0001; tick();
    data_in = 16'h5555; rs = 4'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rd_same_cycle_pre", A, 16'h5555);
`else
    check("rd_same_cycle_pre", A, 16'h0001);
`endif
    tick();
    check("rd_same_cycle_post", A, 16'h5555);

    // Reset priority over a write on the same edge.
    rst = 1'b1; rd = 4'd4; data_in = 16'hFFFF; rs = 4'd4; rt = 4'd5;
    tick();
    check("rst_prio.A", A, 16'h0000);
    check("rst_prio.B", B, 16'h0000);
    rst = 1'b0;
    tick();
    check("rst_release", A, 16'hFFFF);

    // Address boundaries r0 and r15, then verify nothing else moved.
    rd = 4'd0;  data_in = 16'h00FF; tick();
    rd = 4'd15; data_in = 16'hFF00; tick();
    rs = 4'd0; rt = 4'd15;
    #1;
    check("bound.r0", A, 16'h00FF);
    check("bound.r15", B, 16'hFF00);
    for (int i = 1; i < 15; i++) begin
      rs = 4'(i);
      #1;
      check("bound.other", A, (i == 4) ? 16'hFFFF : 16'h0000);
    end

    // Randomized traffic against the model, checking both before and after
    // each edge.
    for (int n = 0; n < 300; n++) begin
      rst     = ($urandom_range(0, 31) == 0);
      rd      = 4'($urandom_range(0, 15));
      data_in = 16'($urandom);
      rs      = 4'($urandom_range(0, 15));
      rt      = ($urandom_range(0, 7) == 0) ? rs : 4'($urandom_range(0, 15));
      check_ports("rand_pre");
      tick();
      check_ports("rand_post");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_reg_file
